// File: rtl/step_dir_pkg.sv
// Shared step/dir encodings and the generator's FSM state type.
// DIR_POS/DIR_NEG are common with step_dir_to_phase.
package step_dir_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} sd_state_t;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/step_dir_gen_pulse_timer.sv
// Loadable down-counter used for the DIR setup, STEP high and STEP low intervals.
// Loading N-1 gives N cycles before zero is seen.
module pulse_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (sclr) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/step_dir_gen.sv
// Step/dir transmitter: signed step command in, timed STEP pulses and DIR level out,
// with a wrapping signed position counter.
//
// state | meaning
// IDLE  | waiting for a command; also hosts the one-cycle done pulse
// SETUP | DIR just changed, holding off the first STEP rise
// HIGH  | STEP high for PULSE_TICKS cycles
// LOW   | STEP low for the rest of the step period
module step_dir_gen
    import step_dir_pkg::*;
#(
    parameter int STEPS_WIDTH     = 32,
    parameter int PERIOD_WIDTH    = 32,
    parameter int PULSE_TICKS     = 7,
    parameter int DIR_SETUP_TICKS = 7
) (
    input  logic                    clk,
    input  logic                    sclr,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [STEPS_WIDTH-1:0]  cmd_steps,
    input  logic [PERIOD_WIDTH-1:0] cmd_period,
    input  logic                    abort,
    output logic                    step,
    output logic                    dir,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [STEPS_WIDTH-1:0]  pos
);

    localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD = PERIOD_WIDTH'(2 * PULSE_TICKS);
    localparam logic [PERIOD_WIDTH-1:0] HIGH_LOAD  = PERIOD_WIDTH'(PULSE_TICKS - 1);
    localparam logic [PERIOD_WIDTH-1:0] SETUP_LOAD = PERIOD_WIDTH'(DIR_SETUP_TICKS - 1);
    localparam logic [PERIOD_WIDTH-1:0] LOW_OFFSET = PERIOD_WIDTH'(PULSE_TICKS + 1);

    sd_state_t               state, state_nxt;
    logic                    step_nxt, dir_nxt, done_nxt, aborted_nxt;
    logic                    abort_pend, abort_pend_nxt;
    logic [STEPS_WIDTH-1:0]  pos_nxt, rem, rem_nxt, mag, pos_stepped;
    logic [PERIOD_WIDTH-1:0] period_q, period_nxt, tmr_value;
    logic                    tmr_load, tmr_zero, new_dir;

    pulse_timer #(.WIDTH(PERIOD_WIDTH)) u_timer (
        .clk   (clk),
        .sclr  (sclr),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    // Magnitude is taken as unsigned so the most negative command still works.
    assign mag         = cmd_steps[STEPS_WIDTH-1] ? -cmd_steps : cmd_steps;
    assign new_dir     = cmd_steps[STEPS_WIDTH-1] ? DIR_NEG : DIR_POS;
    assign pos_stepped = (dir == DIR_NEG) ? pos - STEPS_WIDTH'(1) : pos + STEPS_WIDTH'(1);
    assign cmd_ready   = (state == IDLE) && !done;
    assign busy        = (state != IDLE) || done;

    always_ff @(posedge clk) begin
        if (sclr) begin
            state      <= IDLE;
            step       <= 1'b0;
            dir        <= DIR_POS;
            pos        <= '0;
            rem        <= '0;
            period_q   <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            step       <= step_nxt;
            dir        <= dir_nxt;
            pos        <= pos_nxt;
            rem        <= rem_nxt;
            period_q   <= period_nxt;
            done       <= done_nxt;
            aborted    <= aborted_nxt;
            abort_pend <= abort_pend_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        step_nxt       = step;
        dir_nxt        = dir;
        pos_nxt        = pos;
        rem_nxt        = rem;
        period_nxt     = period_q;
        abort_pend_nxt = abort_pend;
        done_nxt       = 1'b0;
        aborted_nxt    = 1'b0;
        tmr_load       = 1'b0;
        tmr_value      = '0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    period_nxt     = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
                    abort_pend_nxt = 1'b0;
                    if (mag == '0) begin
                        done_nxt = 1'b1;
                    end else if (new_dir != dir) begin
                        state_nxt = SETUP;
                        dir_nxt   = new_dir;
                        rem_nxt   = mag;
                        tmr_load  = 1'b1;
                        tmr_value = SETUP_LOAD;
                    end else begin
                        state_nxt = HIGH;
                        step_nxt  = 1'b1;
                        pos_nxt   = pos_stepped;
                        rem_nxt   = mag - STEPS_WIDTH'(1);
                        tmr_load  = 1'b1;
                        tmr_value = HIGH_LOAD;
                    end
                end
            end
            SETUP: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    done_nxt    = 1'b1;
                    aborted_nxt = 1'b1;
                end else if (tmr_zero) begin
                    state_nxt = HIGH;
                    step_nxt  = 1'b1;
                    pos_nxt   = pos_stepped;
                    rem_nxt   = rem - STEPS_WIDTH'(1);
                    tmr_load  = 1'b1;
                    tmr_value = HIGH_LOAD;
                end
            end
            HIGH: begin
                // An abort seen anywhere in the pulse is held until the pulse width is met.
                if (abort) abort_pend_nxt = 1'b1;
                if (tmr_zero) begin
                    step_nxt = 1'b0;
                    if (abort || abort_pend) begin
                        state_nxt   = IDLE;
                        done_nxt    = 1'b1;
                        aborted_nxt = 1'b1;
                    end else begin
                        state_nxt = LOW;
                        tmr_load  = 1'b1;
                        tmr_value = period_q - LOW_OFFSET;
                    end
                end
            end
            LOW: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    done_nxt    = 1'b1;
                    aborted_nxt = 1'b1;
                end else if (tmr_zero) begin
                    if (rem != '0) begin
                        state_nxt = HIGH;
                        step_nxt  = 1'b1;
                        pos_nxt   = pos_stepped;
                        rem_nxt   = rem - STEPS_WIDTH'(1);
                        tmr_load  = 1'b1;
                        tmr_value = HIGH_LOAD;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
